mandelbrot_iter_engine: RTL

Sequential per-pixel escape-time engine. It accepts one complex point over a valid/ready handshake and iterates z = z^2 + c, one step per clock, until escape or a runtime iteration limit. It then returns the iteration count and an escape flag over a second valid/ready handshake. It is the next generation of the combinational single-step ALU: parametrised width and count, with a Julia mode, overflow-aware escape, and backpressure. It sits between the pixel scanner and the colour mapper.

---
 rtl/mandelbrot_pkg.sv | 21 ++
 rtl/mandelbrot_step_ext.sv | 58 +++++
 rtl/mandelbrot_iter_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared types and width-derived constants for the escape-time engine.
// Helpers take the operand width so per-instance parameters stay the single source of truth.
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Fraction bits of the Q2.(w-2) operand format.
  function automatic int frac_of(input int w);
    return w - 2;
  endfunction

  // |z|^2 escape threshold (4.0) expressed at the product scale.
  function automatic logic [63:0] esc_limit_of(input int w);
    return 64'd4 << (2 * (w - 2));
  endfunction

endpackage

// File: rtl/mandelbrot_step_ext.sv
// One combinational z = z^2 + c step with escape (|z|^2 > 4) and range-overflow detection.
// Stateless so it can be replicated per lane.
module mandelbrot_step_ext
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_zr,
  input  logic [WIDTH-1:0] i_zi,
  input  logic [WIDTH-1:0] i_cr,
  input  logic [WIDTH-1:0] i_ci,
  output logic [WIDTH-1:0] o_nzr,
  output logic [WIDTH-1:0] o_nzi,
  output logic             o_size,
  output logic             o_ovf
);

  localparam int FRAC = frac_of(WIDTH);
  localparam int PW   = 2 * WIDTH;
  localparam int XW   = 2 * WIDTH + 2;
  localparam logic [PW:0] ESC_LIMIT = (PW + 1)'(esc_limit_of(WIDTH));

  logic signed [PW-1:0] w_zr_x, w_zi_x;
  logic signed [PW-1:0] w_m1, w_m2, w_m3;
  logic signed [XW-1:0] w_m1_x, w_m2_x, w_m3_x, w_cr_x, w_ci_x;
  logic signed [XW-1:0] w_nzr_x, w_nzi_x;
  logic [PW:0]          w_mag;
  logic [XW-WIDTH:0]    w_hi_r, w_hi_i;

  assign w_zr_x = {{WIDTH{i_zr[WIDTH-1]}}, i_zr};
  assign w_zi_x = {{WIDTH{i_zi[WIDTH-1]}}, i_zi};

  assign w_m1 = w_zr_x * w_zr_x;
  assign w_m2 = w_zi_x * w_zi_x;
  assign w_m3 = w_zr_x * w_zi_x;

  assign w_m1_x = {{2{w_m1[PW-1]}}, w_m1};
  assign w_m2_x = {{2{w_m2[PW-1]}}, w_m2};
  assign w_m3_x = {{2{w_m3[PW-1]}}, w_m3};
  assign w_cr_x = {{(XW-WIDTH){i_cr[WIDTH-1]}}, i_cr};
  assign w_ci_x = {{(XW-WIDTH){i_ci[WIDTH-1]}}, i_ci};

  // Arithmetic shifts floor toward -inf, matching the reference model.
  assign w_nzr_x = ((w_m1_x - w_m2_x) >>> FRAC) + w_cr_x;
  assign w_nzi_x = ((w_m3_x <<< 1) >>> FRAC) + w_ci_x;

  // Squares are non-negative, so an unsigned sum one bit wider cannot wrap.
  assign w_mag  = {1'b0, w_m1} + {1'b0, w_m2};
  assign o_size = (w_mag > ESC_LIMIT);

  assign w_hi_r = w_nzr_x[XW-1:WIDTH-1];
  assign w_hi_i = w_nzi_x[XW-1:WIDTH-1];
  assign o_ovf  = !((&w_hi_r) | ~(|w_hi_r)) | !((&w_hi_i) | ~(|w_hi_i));

  assign o_nzr = w_nzr_x[WIDTH-1:0];
  assign o_nzi = w_nzi_x[WIDTH-1:0];

endmodule

// File: rtl/mandelbrot_iter_engine.sv
// Per-pixel escape-time engine: accepts a point, iterates one step per clock,
// and holds the count/escape result until the colour mapper takes it.
module mandelbrot_iter_engine
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  julia_en,
  input  logic [WIDTH-1:0]      julia_cr,
  input  logic [WIDTH-1:0]      julia_ci,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_pr,
  input  logic [WIDTH-1:0]      in_pi,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ITER_WIDTH-1:0] out_count,
  output logic                  out_escaped
);

  state_t                r_state, w_next;
  logic [WIDTH-1:0]      r_zr, r_zi, r_cr, r_ci;
  logic [ITER_WIDTH-1:0] r_iter, r_max;
  logic [ITER_WIDTH-1:0] r_count;
  logic                  r_escaped;

  logic [WIDTH-1:0]      w_nzr, w_nzi;
  logic                  w_size, w_ovf, w_exit, w_last, w_accept;

  mandelbrot_step_ext #(.WIDTH(WIDTH)) u_step (
    .i_zr   (r_zr),
    .i_zi   (r_zi),
    .i_cr   (r_cr),
    .i_ci   (r_ci),
    .o_nzr  (w_nzr),
    .o_nzi  (w_nzi),
    .o_size (w_size),
    .o_ovf  (w_ovf)
  );

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_count   = r_count;
  assign out_escaped = r_escaped;

  assign w_accept = in_valid & in_ready;
  assign w_exit   = w_size | w_ovf;
  assign w_last   = (({1'b0, r_iter} + (ITER_WIDTH + 1)'(1)) == {1'b0, r_max});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (max_iter == '0) ? S_DONE : S_ITER;
      S_ITER: if (w_exit || w_last) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort wins over every transition, including a completing handshake.
    if (clear) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zr      <= '0;
      r_zi      <= '0;
      r_cr      <= '0;
      r_ci      <= '0;
      r_iter    <= '0;
      r_max     <= '0;
      r_count   <= '0;
      r_escaped <= 1'b0;
    end else if (!clear) begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (julia_en) begin
            r_zr <= in_pr;
            r_zi <= in_pi;
            r_cr <= julia_cr;
            r_ci <= julia_ci;
          end else begin
            r_zr <= '0;
            r_zi <= '0;
            r_cr <= in_pr;
            r_ci <= in_pi;
          end
          r_iter <= '0;
          r_max  <= max_iter;
          if (max_iter == '0) begin
            r_count   <= '0;
            r_escaped <= 1'b0;
          end
        end
        S_ITER: begin
          if (w_exit) begin
            r_count   <= r_iter;
            r_escaped <= 1'b1;
          end else if (w_last) begin
            r_count   <= r_max;
            r_escaped <= 1'b0;
          end else begin
            r_zr   <= w_nzr;
            r_zi   <= w_nzi;
            r_iter <= r_iter + ITER_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
